// File: rtl/address_gen_pipe.sv
// address_gen_pipe: two-stage LC-3b address generator.
// Stage 1 selects the base (ADDR1) and forms the extended, shifted IR offset
// (ADDR2). Stage 2 adds them and presents OUT/CARRY/ALIGN_FAULT under a
// valid/ready handshake. Each stage holds its contents while the stage ahead
// of it is blocked, so no request is dropped or duplicated.
module address_gen_pipe #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 2
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [1:0]         ADDR1_SEL,
  input  logic [2:0]         ADDR2_SEL,
  input  logic [SHAMT_W-1:0] SHAMT,
  input  logic               WORD,
  input  logic [WIDTH-1:0]   IR,
  input  logic [WIDTH-1:0]   PC,
  input  logic [WIDTH-1:0]   SR1,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [WIDTH-1:0]   OUT,
  output logic               CARRY,
  output logic               ALIGN_FAULT
);

  // ADDR1 source encodings; ZERO and the reserved code both give a zero base.
  localparam logic [1:0] A1_PC    = 2'd0;
  localparam logic [1:0] A1_BASER = 2'd1;

  // ADDR2 source encodings; codes 5..7 give a zero offset.
  localparam logic [2:0] A2_OFF6  = 3'd1;
  localparam logic [2:0] A2_OFF9  = 3'd2;
  localparam logic [2:0] A2_OFF11 = 3'd3;
  localparam logic [2:0] A2_TRAP8 = 3'd4;

  // Extend the selected IR field to the datapath width. Signed offsets
  // replicate their MSB; the trap vector is zero-filled.
  function automatic logic [WIDTH-1:0] ext_offset(input logic [2:0]  sel,
                                                  input logic [10:0] ir_low);
    logic [WIDTH-1:0] ext;
    case (sel)
      A2_OFF6:  ext = {{(WIDTH-6){ir_low[5]}}, ir_low[5:0]};
      A2_OFF9:  ext = {{(WIDTH-9){ir_low[8]}}, ir_low[8:0]};
      A2_OFF11: ext = {{(WIDTH-11){ir_low[10]}}, ir_low[10:0]};
      A2_TRAP8: ext = {{(WIDTH-8){1'b0}}, ir_low[7:0]};
      default:  ext = {WIDTH{1'b0}};
    endcase
    return ext;
  endfunction

  // A word access is misaligned when the byte address is odd.
  function automatic logic misaligned(input logic is_word, input logic addr_lsb);
    return is_word & addr_lsb;
  endfunction

  // Stage 1 (operand) state.
  logic               s1_valid_r;
  logic [WIDTH-1:0]   s1_a_r;
  logic [WIDTH-1:0]   s1_b_r;
  logic               s1_word_r;

  // Stage 2 (result) state, driven straight onto the outputs.
  logic               out_valid_r;
  logic [WIDTH-1:0]   out_r;
  logic               carry_r;
  logic               align_fault_r;

  // Combinational operands and handshake terms.
  logic [WIDTH-1:0]   a_s;
  logic [WIDTH-1:0]   ext_s;
  logic [WIDTH-1:0]   b_s;
  logic [WIDTH:0]     sum_s;
  logic               s2_adv_s;
  logic               in_ready_s;
  logic               accept_s;

  // IR bits above the widest offset field never feed the address.
  logic               unused_ir_s;
  assign unused_ir_s = ^IR[WIDTH-1:11];

  // Handshake: stage 2 can take new data when empty or being drained; stage 1
  // can take a request when empty or when it is moving into stage 2.
  always_comb begin
    s2_adv_s   = (~out_valid_r) | OUT_READY;
    in_ready_s = (~s1_valid_r) | s2_adv_s;
    accept_s   = IN_VALID & in_ready_s;
  end

  // Base select: PC, base register, or zero for the ZERO/reserved codes.
  always_comb begin
    a_s = {WIDTH{1'b0}};
    case (ADDR1_SEL)
      A1_PC:    a_s = PC;
      A1_BASER: a_s = SR1;
      default:  a_s = {WIDTH{1'b0}};
    endcase
  end

  // Offset: extend then shift left; bits pushed past the MSB are dropped.
  always_comb begin
    ext_s = ext_offset(ADDR2_SEL, IR[10:0]);
    b_s   = ext_s << SHAMT;
  end

  // Full-width add with carry out of the top bit.
  always_comb begin
    sum_s = {1'b0, s1_a_r} + {1'b0, s1_b_r};
  end

  // Stage 1 register: load on accept, otherwise empty out when the operands
  // move forward, otherwise hold while stage 2 is blocked.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_word_r  <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= a_s;
      s1_b_r     <= b_s;
      s1_word_r  <= WORD;
    end else if (s2_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2 register: capture the sum when stage 1 advances, clear the valid
  // flag on a bubble, and hold everything while the consumer stalls.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_valid_r   <= 1'b0;
      out_r         <= {WIDTH{1'b0}};
      carry_r       <= 1'b0;
      align_fault_r <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_r         <= sum_s[WIDTH-1:0];
        carry_r       <= sum_s[WIDTH];
        align_fault_r <= misaligned(s1_word_r, sum_s[0]);
      end else begin
        out_r         <= out_r;
        carry_r       <= carry_r;
        align_fault_r <= align_fault_r;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign IN_READY    = in_ready_s;
  assign OUT_VALID   = out_valid_r;
  assign OUT         = out_r;
  assign CARRY       = carry_r;
  assign ALIGN_FAULT = align_fault_r;

endmodule

// File: tb/tb_address_gen_pipe.sv
// Self-checking bench for address_gen_pipe: a queue-based model predicts
// every result from the addressing rules, and a per-cycle compare checks
// valid timing, data, stall stability and IN_READY against it.
module tb_address_gen_pipe;

  logic        CLK;
  logic        RESET_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [1:0]  ADDR1_SEL;
  logic [2:0]  ADDR2_SEL;
  logic [1:0]  SHAMT;
  logic        WORD;
  logic [15:0] IR;
  logic [15:0] PC;
  logic [15:0] SR1;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] OUT;
  logic        CARRY;
  logic        ALIGN_FAULT;

  // 24-bit instance
  logic        v24;
  logic        rdy24;
  logic [1:0]  a1_24;
  logic [2:0]  a2_24;
  logic [1:0]  sh24;
  logic        wd24;
  logic [23:0] ir24;
  logic [23:0] pc24;
  logic [23:0] sr1_24;
  logic        ov24;
  logic        ordy24;
  logic [23:0] out24;
  logic        c24;
  logic        f24;

  address_gen_pipe #(.WIDTH(16), .SHAMT_W(2)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ADDR1_SEL(ADDR1_SEL), .ADDR2_SEL(ADDR2_SEL), .SHAMT(SHAMT), .WORD(WORD),
    .IR(IR), .PC(PC), .SR1(SR1), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT(OUT), .CARRY(CARRY), .ALIGN_FAULT(ALIGN_FAULT)
  );

  address_gen_pipe #(.WIDTH(24), .SHAMT_W(2)) u_dut24 (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(v24), .IN_READY(rdy24),
    .ADDR1_SEL(a1_24), .ADDR2_SEL(a2_24), .SHAMT(sh24), .WORD(wd24),
    .IR(ir24), .PC(pc24), .SR1(sr1_24), .OUT_VALID(ov24), .OUT_READY(ordy24),
    .OUT(out24), .CARRY(c24), .ALIGN_FAULT(f24)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int          acc;
    logic [15:0] out;
    logic        carry;
    logic        fault;
  } exp_t;

  exp_t        q[$];
  int          checks;
  int          failures;
  int          cyc;
  bit          accepted;
  bit          popped;
  bit          prev_stall;
  logic [15:0] last_out;
  logic        last_carry;
  logic        last_fault;
  logic [15:0] snap_out;
  logic        snap_carry;
  logic        snap_fault;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Address rules in plain integer arithmetic.
  function automatic void model(input int w, input int a1, input int a2,
                                input int sh, input int wd,
                                input longint ir, input longint pc,
                                input longint sr1, output longint out,
                                output bit carry, output bit fault);
    longint mask;
    longint a;
    longint off;
    longint b;
    longint sum;
    mask = (longint'(1) << w) - 1;
    a = (a1 == 0) ? pc : (a1 == 1) ? sr1 : 0;
    case (a2)
      1: begin off = ir & 63;   if (off >= 32)   off -= 64;   end
      2: begin off = ir & 511;  if (off >= 256)  off -= 512;  end
      3: begin off = ir & 2047; if (off >= 1024) off -= 2048; end
      4: off = ir & 255;
      default: off = 0;
    endcase
    b = (off << sh) & mask;
    sum = (a & mask) + b;
    out = sum & mask;
    carry = ((sum >> w) & 1) != 0;
    fault = (wd != 0) && ((out & 1) != 0);
  endfunction

  // One clock of stimulus plus the full per-cycle comparison.
  task automatic step(input logic iv, input logic [1:0] s1, input logic [2:0] s2,
                      input logic [1:0] sh, input logic wd, input logic [15:0] ir,
                      input logic [15:0] pc, input logic [15:0] sr1,
                      input logic ordy);
    bit     exp_valid;
    bit     exp_rdy;
    longint o;
    bit     c;
    bit     f;
    exp_t   e;
    @(negedge CLK);
    IN_VALID = iv; ADDR1_SEL = s1; ADDR2_SEL = s2; SHAMT = sh; WORD = wd;
    IR = ir; PC = pc; SR1 = sr1; OUT_READY = ordy;
    #1;
    exp_valid = (q.size() > 0) && (q[0].acc + 2 <= cyc);
    chk("out_valid", OUT_VALID, exp_valid);
    if (exp_valid) begin
      chk("out", OUT, q[0].out);
      chk("carry", CARRY, q[0].carry);
      chk("align_fault", ALIGN_FAULT, q[0].fault);
    end
    if (prev_stall) begin
      chk("stall_out", OUT, snap_out);
      chk("stall_carry", CARRY, snap_carry);
      chk("stall_fault", ALIGN_FAULT, snap_fault);
    end
    exp_rdy = !(q.size() == 2 && !ordy);
    chk("in_ready", IN_READY, exp_rdy);
    popped = exp_valid && ordy;
    if (popped) begin
      last_out = q[0].out; last_carry = q[0].carry; last_fault = q[0].fault;
      void'(q.pop_front());
    end
    accepted = iv && exp_rdy;
    if (accepted) begin
      model(16, s1, s2, sh, wd, ir, pc, sr1, o, c, f);
      e.acc = cyc; e.out = o[15:0]; e.carry = c; e.fault = f;
      q.push_back(e);
    end
    prev_stall = exp_valid && !ordy;
    snap_out = OUT; snap_carry = CARRY; snap_fault = ALIGN_FAULT;
    cyc++;
  endtask

  // One isolated request into an empty pipe, with latency and literal result.
  task automatic single(input string nm, input logic [1:0] s1, input logic [2:0] s2,
                        input logic [1:0] sh, input logic wd, input logic [15:0] ir,
                        input logic [15:0] pc, input logic [15:0] sr1,
                        input logic [15:0] xo, input logic xc, input logic xf);
    int n;
    n = 0; accepted = 0;
    while (!accepted && n < 10) begin
      step(1'b1, s1, s2, sh, wd, ir, pc, sr1, 1'b1);
      n++;
    end
    chk({nm, "_accept"}, accepted, 1);
    n = 0; popped = 0;
    while (!popped && n < 10) begin
      step(1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
      n++;
    end
    chk({nm, "_latency"}, n, 2);
    chk({nm, "_out"}, last_out, xo);
    chk({nm, "_carry"}, last_carry, xc);
    chk({nm, "_fault"}, last_fault, xf);
  endtask

  task automatic run24(input string nm, input logic [2:0] sel, input logic [23:0] ir,
                       input logic [23:0] sr1, input logic [23:0] xo, input logic xc);
    int n;
    @(negedge CLK);
    v24 = 1'b1; a1_24 = 2'd1; a2_24 = sel; ir24 = ir; sr1_24 = sr1;
    #1;
    chk({nm, "_in_ready"}, rdy24, 1);
    @(negedge CLK);
    v24 = 1'b0;
    n = 0;
    #1;
    while (!ov24 && n < 6) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk({nm, "_valid"}, ov24, 1);
    chk({nm, "_latency"}, n, 1);
    chk({nm, "_out"}, out24, xo);
    chk({nm, "_carry"}, c24, xc);
  endtask

  initial begin
    longint o;
    bit     c;
    bit     f;
    int     sent;
    int     got;
    int     k;
    checks = 0; failures = 0; cyc = 0; prev_stall = 0;
    RESET_N = 1'b0; IN_VALID = 1'b1; ADDR1_SEL = 2'd0; ADDR2_SEL = 3'd0;
    SHAMT = 2'd0; WORD = 1'b0; IR = 16'd0; PC = 16'd5; SR1 = 16'd0;
    OUT_READY = 1'b1;
    v24 = 1'b0; a1_24 = 2'd0; a2_24 = 3'd0; sh24 = 2'd0; wd24 = 1'b0;
    ir24 = 24'd0; pc24 = 24'd0; sr1_24 = 24'd0; ordy24 = 1'b1;

    // Pin the model to hand-computed values.
    model(16, 0, 1, 0, 0, 'hFFFF, 5, 0, o, c, f);
    chk("model_off6", o, 'h0004);
    chk("model_off6_carry", c, 1);
    model(16, 2, 4, 1, 1, 'h0025, 0, 0, o, c, f);
    chk("model_trap", o, 'h004A);
    model(24, 1, 7, 0, 0, 0, 0, 'hFFFFFF, o, c, f);
    chk("model_reserved24", o, 'hFFFFFF);

    // Reset state (requests presented during reset are ignored).
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out", OUT, 0);
    chk("rst_carry", CARRY, 0);
    chk("rst_fault", ALIGN_FAULT, 0);
    chk("rst_in_ready", IN_READY, 1);
    IN_VALID = 1'b0;
    RESET_N = 1'b1;

    // Directed cases.
    single("pc_zero",  2'd0, 3'd0, 2'd0, 1'b0, 16'h0000, 16'd5,   16'h0000, 16'h0005, 1'b0, 1'b0);
    single("off6",     2'd0, 3'd1, 2'd0, 1'b0, 16'hFFFF, 16'd5,   16'h0000, 16'h0004, 1'b1, 1'b0);
    single("off9",     2'd0, 3'd2, 2'd0, 1'b0, 16'hFF01, 16'd256, 16'h0000, 16'h0001, 1'b1, 1'b0);
    single("off11",    2'd0, 3'd3, 2'd0, 1'b0, 16'hFF9C, 16'd200, 16'h0000, 16'd100,  1'b1, 1'b0);
    single("baser_sh", 2'd1, 3'd3, 2'd1, 1'b1, 16'hFFFF, 16'd0,   16'h0040, 16'h003E, 1'b1, 1'b0);
    single("trap_sh",  2'd2, 3'd4, 2'd1, 1'b0, 16'h0025, 16'h1234, 16'h5678, 16'h004A, 1'b0, 1'b0);
    single("trap_wd",  2'd2, 3'd4, 2'd0, 1'b1, 16'h0025, 16'h1234, 16'h5678, 16'h0025, 1'b0, 1'b1);
    single("rsvd",     2'd3, 3'd6, 2'd3, 1'b0, 16'hFFFF, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0);

    // Back-to-back stream with OUT_READY 1,0,0,1,...
    sent = 0; got = 0; k = 0;
    while (got < 8 && k < 200) begin
      step(sent < 8, 2'd0, 3'd1, 2'd0, 1'b0, 16'h0001, 16'(sent), 16'd0,
           (k % 4 == 0) || (k % 4 == 3));
      if (accepted) sent++;
      if (popped) begin
        chk("stream_order", last_out, got + 1);
        got++;
      end
      k++;
    end
    chk("stream_count", got, 8);

    // Reset with two requests in flight.
    step(1'b1, 2'd0, 3'd0, 2'd0, 1'b0, 16'd0, 16'h0AAA, 16'd0, 1'b0);
    step(1'b1, 2'd0, 3'd0, 2'd0, 1'b0, 16'd0, 16'h0BBB, 16'd0, 1'b0);
    @(negedge CLK);
    IN_VALID = 1'b1;
    RESET_N = 1'b0;
    #1;
    chk("midrst_out_valid", OUT_VALID, 0);
    chk("midrst_out", OUT, 0);
    q.delete();
    prev_stall = 0;
    @(negedge CLK);
    RESET_N = 1'b1;
    IN_VALID = 1'b0;
    repeat (3) step(1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
    single("post_rst", 2'd1, 3'd1, 2'd0, 1'b0, 16'h0003, 16'd0, 16'h0100, 16'h0103, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom),
           16'($urandom), 16'($urandom), $urandom_range(0, 9) < 6);
    end
    k = 0;
    while (q.size() > 0 && k < 10) begin
      step(1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1);
      k++;
    end
    chk("drain_empty", q.size(), 0);

    // 24-bit build.
    run24("w24_off6", 3'd1, 24'h000001, 24'hFFFFFF, 24'h000000, 1'b1);
    run24("w24_rsvd", 3'd7, 24'h00FFFF, 24'h123456, 24'h123456, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/address_gen_pipe.md
Name: address_gen_pipe

Overview:
Pipelined, parametrised address-generation unit for the LC-3b datapath. It forms ADDR1 + (sign/zero-extended, left-shifted IR offset) and returns the result with a valid/ready handshake two cycles later. Compared with the combinational address adder, it adds:
- width generics and a multi-bit shift amount;
- a zero base and a zero-extended trap-vector mode;
- carry and word-alignment fault flags.

It sits between the IR/regfile/PC sources and MAR/PC mux consumers.

Parameters:
WIDTH, 16, datapath/address width in bits (>= 12)
SHAMT_W, 2, width of shift-amount input (shift 0..2^SHAMT_W-1)

Ports:
CLK  input  1  rising-edge clock
RESET_N  input  1  asynchronous active-low reset
IN_VALID  input  1  request valid
IN_READY  output  1  unit can accept request this cycle
ADDR1_SEL  input  2  0=PC, 1=BASER(SR1), 2=ZERO, 3=reserved (treated as ZERO)
ADDR2_SEL  input  3  0=ZERO, 1=OFFSET6 sext IR[5:0], 2=PCOFFSET9 sext IR[8:0], 3=PCOFFSET11 sext IR[10:0], 4=TRAPVECT8 zext IR[7:0], 5-7 treated as ZERO
SHAMT  input  SHAMT_W  left shift applied to ADDR2 operand
WORD  input  1  access is word-sized; alignment is checked
IR  input  WIDTH  instruction register
PC  input  WIDTH  program counter
SR1  input  WIDTH  base register value
OUT_VALID  output  1  result valid
OUT_READY  input  1  consumer accepts result
OUT  output  WIDTH  computed address
CARRY  output  1  carry out of the WIDTH-bit add (unsigned wrap)
ALIGN_FAULT  output  1  WORD=1 and OUT[0]=1

Behaviour:
- Reset (RESET_N low, asynchronous):
  - all stage valid flags clear; OUT_VALID=0;
  - OUT, CARRY, ALIGN_FAULT=0;
  - IN_READY=1 once reset deasserts. IN_READY is 1 during reset as well, but requests are ignored while RESET_N is low.
- Reset mid-operation discards all in-flight requests; no partial result appears after release.
- Stage 1 (operand): on IN_VALID && IN_READY, it registers:
  - A = mux(ADDR1_SEL);
  - B = ext(ADDR2_SEL) << SHAMT, truncated to WIDTH;
  - WORD.
- Extension rules:
  - sext replicates the offset MSB to WIDTH;
  - TRAPVECT8 fills the upper bits with 0;
  - bits shifted beyond WIDTH are dropped.
- Stage 2 (add): {CARRY, OUT} = A + B (WIDTH+1 bits). ALIGN_FAULT = WORD & sum[0]. Registered with OUT_VALID.
- Latency: exactly 2 cycles from accept to OUT_VALID when there is no back-pressure.
- Throughput: 1 request/cycle.
- Handshake:
  - s2_adv = !OUT_VALID || OUT_READY;
  - s1 moves into s2 when s1_valid && s2_adv;
  - IN_READY = !s1_valid || s2_adv. IN_READY is combinational from OUT_READY, with no dependency on IN_VALID.
- Stall: OUT, CARRY, ALIGN_FAULT and OUT_VALID hold stable while OUT_VALID && !OUT_READY. Stage 1 holds its contents while blocked. No request is dropped or duplicated.
- Full pipeline (both stages valid, OUT_READY=0): IN_READY=0.
- Simultaneous output handshake and input accept in the same cycle is legal; the pipeline stays full.
- Bubbles: an empty stage 1 with OUT_READY=1 drains stage 2 and clears OUT_VALID.
- Inputs IR/PC/SR1/selects are sampled only at accept. Later changes do not affect in-flight results.
- ALIGN_FAULT is informational only. The address is still delivered unmodified.
- Reserved select encodings are treated as zero and are not flagged.

Test Plan:
- Reset then PC=5, ADDR1=PC, ADDR2=ZERO, SHAMT=0, one request -> OUT_VALID rises exactly 2 cycles after accept. OUT=0x0005, CARRY=0, ALIGN_FAULT=0.
- Extension cases, all with SHAMT=0:
  - PC=5, IR=0xFFFF, OFFSET6 -> OUT=0x0004, CARRY=1;
  - PC=256, IR=-255, PCOFFSET9 -> OUT=0x0001;
  - PC=200, IR=-100, PCOFFSET11 -> OUT=100.
- Shift and trap cases:
  - SR1=0x40, IR=0xFFFF, BASER, PCOFFSET11, SHAMT=1, WORD=1 -> OUT=0x003E, ALIGN_FAULT=0;
  - ADDR1=ZERO, IR=0x0025, TRAPVECT8, SHAMT=1 -> OUT=0x004A;
  - same with SHAMT=0 and WORD=1 -> OUT=0x0025, ALIGN_FAULT=1.
- Back-to-back stream of 8 requests (PC=0..7, OFFSET6, IR=1) with OUT_READY toggling 1,0,0,1,… -> results 1..8 appear in order, none lost or repeated. Outputs are stable during stalls. IN_READY=0 whenever both stages are full and OUT_READY=0.
- Assert RESET_N=0 for 1 cycle while 2 requests are in flight -> OUT_VALID drops immediately (asynchronously) and OUT=0. No stale result appears after release. The next request returns its correct value 2 cycles after accept.
- WIDTH=24 build: SR1=0xFFFFFF, OFFSET6 with IR=0x0001 -> OUT=0x000000, CARRY=1. With reserved ADDR2_SEL=7 -> OUT=SR1.
